// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and helpers for the BCD 7-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would carry past 9 after doubling.
    function automatic logic [3:0] dabble_adj(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One digit of active-low segment decode; a set blank flag forces the digit dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Nibble-to-pattern lookup; non-decimal codes go dark
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_bcd_display.sv
// Binary-to-decimal 7-segment driver: serial double-dabble conversion (one bit per clock)
// followed by a registered per-digit decode with leading-zero blanking and overflow dashes.
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 3,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      din,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [DIGITS*7-1:0]   seg
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(BIN_W);
    localparam logic [63:0]      OVF_LIMIT = pow10(DIGITS);

    state_t                     state_r;
    logic [BIN_W-1:0]           shift_r;
    logic [BCD_W-1:0]           bcd_r;
    logic [CNT_W-1:0]           cnt_r;
    logic                       ovf_next_r;
    logic                       ovf_r;
    logic                       busy_r;
    logic                       done_r;
    logic [DIGITS*7-1:0]        seg_r;

    logic                       din_ovf_s;
    logic [BCD_W-1:0]           bcd_adj_s;
    logic [BCD_W+BIN_W-1:0]     step_s;
    logic [DIGITS-1:0]          blank_s;
    logic [DIGITS*7-1:0]        dec_seg_s;

    assign din_ovf_s = (64'(din) >= OVF_LIMIT);

    // Add-3 correction on every BCD nibble ahead of the shift
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = dabble_adj(bcd_r[4*i +: 4]);
        end
    end

    assign step_s = {bcd_adj_s, shift_r} << 1;

    // Blank digit i>0 when it and every digit above it are zero
    always_comb begin
        logic zero_run_s;
        zero_run_s = 1'b1;
        blank_s    = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run_s = zero_run_s & (bcd_r[4*i +: 4] == 4'd0);
            blank_s[i] = (LZB != 0) & zero_run_s;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decode u_decode (
            .nibble (bcd_r[4*g +: 4]),
            .blank  (blank_s[g]),
            .seg    (dec_seg_s[7*g +: 7])
        );
    end

    // Conversion sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            ovf_next_r <= 1'b0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            seg_r      <= '1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load) begin
                        shift_r    <= din;
                        bcd_r      <= '0;
                        cnt_r      <= CNT_INIT;
                        ovf_next_r <= din_ovf_s;
                        busy_r     <= 1'b1;
                        state_r    <= CONV;
                    end
                end
                CONV: begin
                    bcd_r   <= step_s[BCD_W+BIN_W-1:BIN_W];
                    shift_r <= step_s[BIN_W-1:0];
                    cnt_r   <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= UPDATE;
                    end
                end
                UPDATE: begin
                    seg_r   <= ovf_next_r ? {DIGITS{SEG_DASH}} : dec_seg_s;
                    ovf_r   <= ovf_next_r;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ovf  = ovf_r;
    assign seg  = seg_r;

endmodule
